// File: rtl/old_control_logic_pkg.sv
// Shared MIPS-subset decode definitions: opcodes, ALUop classes and the
// control-bundle struct passed between the decoder and the datapath.
package old_control_logic_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       alu_src;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_write;
    logic       mem_read;
    logic       beq;
    logic       bne;
    logic       jump;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/old_control_logic_decode.sv
// Purely combinational opcode -> control-bundle decode. Anything outside the
// supported set, including X/Z bits, falls to the all-zero NOP with illegal set.
module old_control_logic_decode
  import old_control_logic_pkg::*;
(
  input  logic [5:0] opcode_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (opcode_i)
      OP_RTYPE: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.alu_op    = ALUOP_FUNCT;
        ctrl_o.reg_write = 1'b1;
      end
      OP_LW: begin
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.alu_op     = ALUOP_ADD;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
      end
      OP_SW: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl_o.alu_op = ALUOP_SUB;
        ctrl_o.beq    = 1'b1;
      end
      OP_BNE: begin
        ctrl_o.alu_op = ALUOP_SUB;
        ctrl_o.bne    = 1'b1;
      end
      OP_J: begin
        ctrl_o.alu_op = ALUOP_ADD;
        ctrl_o.jump   = 1'b1;
      end
      OP_ADDI: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.reg_write = 1'b1;
      end
      default: ctrl_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/old_control_logic.sv
// Main control decoder: combinational decode followed by a single output
// register whose asynchronous reset forces a NOP (no memory/register writes).
module old_control_logic
  import old_control_logic_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  output logic       ALUsrc,
  output logic [1:0] ALUop,
  output logic       RegDst,
  output logic       MemWrite,
  output logic       MemRead,
  output logic       Beq,
  output logic       Bne,
  output logic       Jump,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       Illegal
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  old_control_logic_decode u_decode (
    .opcode_i (opcode),
    .ctrl_o   (ctrl_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctrl_q <= '0;
    else        ctrl_q <= ctrl_d;
  end

  assign ALUsrc   = ctrl_q.alu_src;
  assign ALUop    = ctrl_q.alu_op;
  assign RegDst   = ctrl_q.reg_dst;
  assign MemWrite = ctrl_q.mem_write;
  assign MemRead  = ctrl_q.mem_read;
  assign Beq      = ctrl_q.beq;
  assign Bne      = ctrl_q.bne;
  assign Jump     = ctrl_q.jump;
  assign MemToReg = ctrl_q.mem_to_reg;
  assign RegWrite = ctrl_q.reg_write;
  assign Illegal  = ctrl_q.illegal;

endmodule

// File: tb/tb_old_control_logic.sv
// Self-checking bench for old_control_logic against a table-lookup model of
// the opcode decode with a one-cycle registered latency.
module tb_old_control_logic;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'b000000;
  logic       ALUsrc, RegDst, MemWrite, MemRead, Beq, Bne, Jump, MemToReg, RegWrite, Illegal;
  logic [1:0] ALUop;

  int vectors = 0;
  int miscompares = 0;

  old_control_logic dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
    .ALUsrc   (ALUsrc),
    .ALUop    (ALUop),
    .RegDst   (RegDst),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .Beq      (Beq),
    .Bne      (Bne),
    .Jump     (Jump),
    .MemToReg (MemToReg),
    .RegWrite (RegWrite),
    .Illegal  (Illegal)
  );

  always #5 clk = ~clk;

  // Field order: ALUsrc ALUop[1:0] RegDst MemWrite MemRead Beq Bne Jump MemToReg RegWrite Illegal
  logic [11:0] obs;
  assign obs = {ALUsrc, ALUop, RegDst, MemWrite, MemRead, Beq, Bne, Jump, MemToReg, RegWrite, Illegal};

  localparam logic [5:0] OPS [7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                     6'b000101, 6'b000010, 6'b001000};
  localparam logic [11:0] CTLS [7] = '{
    12'b0_10_1_0_0_0_0_0_0_1_0,   // R-type
    12'b1_00_0_0_1_0_0_0_1_1_0,   // lw
    12'b1_00_0_1_0_0_0_0_0_0_0,   // sw
    12'b0_01_0_0_0_1_0_0_0_0_0,   // beq
    12'b0_01_0_0_0_0_1_0_0_0_0,   // bne
    12'b0_00_0_0_0_0_0_1_0_0_0,   // j
    12'b1_00_0_0_0_0_0_0_0_1_0    // addi
  };
  localparam logic [11:0] NOP_ILLEGAL = 12'b0_00_0_0_0_0_0_0_0_0_1;

  function automatic logic [11:0] model(input logic [5:0] op);
    for (int i = 0; i < 7; i++)
      if (OPS[i] == op) return CTLS[i];
    return NOP_ILLEGAL;
  endfunction

  // Present op before an edge, then sample just after that edge.
  task automatic step(input logic [5:0] op);
    @(negedge clk);
    opcode = op;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    opcode = 6'b000000;
    #2;
    vectors++;
    if (obs !== 12'b0) begin
      $display("FAIL reset_state obs=%b exp=%b", obs, 12'b0);
      miscompares++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (obs !== model(6'b000000)) begin
      $display("FAIL reset_release obs=%b exp=%b", obs, model(6'b000000));
      miscompares++;
    end
  endtask

  task automatic test_sequence();
    logic [5:0] seq [4] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100};
    logic [11:0] prev;
    prev = obs;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      opcode = seq[i];
      #1;
      vectors++;
      if (obs !== prev) begin
        $display("FAIL hold_before_edge op=%b obs=%b exp=%b", seq[i], obs, prev);
        miscompares++;
      end
      @(posedge clk);
      #1;
      vectors++;
      if (obs !== model(seq[i])) begin
        $display("FAIL sequence op=%b obs=%b exp=%b", seq[i], obs, model(seq[i]));
        miscompares++;
      end
      prev = obs;
    end
  endtask

  task automatic test_illegal();
    logic [5:0] bad [2] = '{6'b111011, 6'b100001};
    for (int i = 0; i < 2; i++) begin
      step(bad[i]);
      vectors++;
      if (obs !== NOP_ILLEGAL) begin
        $display("FAIL illegal op=%b obs=%b exp=%b", bad[i], obs, NOP_ILLEGAL);
        miscompares++;
      end
    end
  endtask

  task automatic test_other_ops();
    logic [5:0] ops [3] = '{6'b000101, 6'b000010, 6'b001000};
    for (int i = 0; i < 3; i++) begin
      step(ops[i]);
      vectors++;
      if (obs !== model(ops[i])) begin
        $display("FAIL other_ops op=%b obs=%b exp=%b", ops[i], obs, model(ops[i]));
        miscompares++;
      end
    end
  endtask

  task automatic test_sweep();
    int illegalCount = 0;
    for (int c = 0; c < 64; c++) begin
      step(6'(c));
      vectors++;
      if (obs !== model(6'(c))) begin
        $display("FAIL sweep op=%b obs=%b exp=%b", 6'(c), obs, model(6'(c)));
        miscompares++;
      end
      vectors++;
      if ((MemRead && MemWrite) || ($countones({Beq, Bne, Jump}) > 1) || (ALUop == 2'b11) ||
          (MemWrite && RegWrite) || (MemToReg && !MemRead)) begin
        $display("FAIL sweep_invariant op=%b obs=%b", 6'(c), obs);
        miscompares++;
      end
      if (Illegal) illegalCount++;
    end
    vectors++;
    if (illegalCount != 57) begin
      $display("FAIL illegal_count obs=%0d exp=%0d", illegalCount, 57);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] op;
    for (int i = 0; i < 200; i++) begin
      op = ($urandom_range(0, 1) == 0) ? OPS[$urandom_range(0, 6)] : 6'($urandom);
      step(op);
      vectors++;
      if (obs !== model(op)) begin
        $display("FAIL random op=%b obs=%b exp=%b", op, obs, model(op));
        miscompares++;
      end
    end
  endtask

  task automatic test_mid_reset();
    step(6'b100011);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (obs !== 12'b0) begin
      $display("FAIL mid_reset_clear obs=%b exp=%b", obs, 12'b0);
      miscompares++;
    end
    opcode = 6'b101011;
    @(posedge clk);
    #1;
    vectors++;
    if (obs !== 12'b0) begin
      $display("FAIL reset_held_edge obs=%b exp=%b", obs, 12'b0);
      miscompares++;
    end
    @(negedge clk);
    opcode = 6'b000101;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (obs !== model(6'b000101)) begin
      $display("FAIL post_reset_decode obs=%b exp=%b", obs, model(6'b000101));
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_illegal();
    test_other_ops();
    test_sweep();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
